// File: rtl/snn_core_param.sv
// snn_core_param: two-layer fully-connected inference core with an argmax stage.
// Each neuron computes an 8-bit signed multiply-accumulate, saturates it and
// looks the result up in an activation LUT. The hidden activations are kept in
// an internal register file. After the last output neuron, the index and value
// of the largest output activation are reported.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        begin inference (taken only in IDLE) / return to IDLE
//   in_addr / in_q      binary input-pixel memory (1-cycle read latency)
//   hw_addr / hw_q      hidden weights, address {h, i} (1-cycle read latency)
//   ow_addr / ow_q      output weights, address {o, h} (1-cycle read latency)
//   lut_addr / lut_q    activation LUT (1-cycle read latency)
//   busy                high in every state except IDLE
//   done                one-cycle pulse when digit/max_val are final
//   digit, max_val      argmax index and the winning activation
module snn_core_param #(
  parameter int N_IN   = 784,
  parameter int N_HID  = 32,
  parameter int N_OUT  = 10,   // at most 16, so that digit fits in 4 bits
  parameter int ACC_W  = 26,
  parameter int FRAC   = 7,
  parameter int LUT_AW = 11,
  localparam int IA_W  = $clog2(N_IN),
  localparam int HA_W  = $clog2(N_HID),
  localparam int OA_W  = $clog2(N_OUT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [IA_W-1:0]      in_addr,
  input  logic                 in_q,
  output logic [HA_W+IA_W-1:0] hw_addr,
  input  logic [7:0]           hw_q,
  output logic [OA_W+HA_W-1:0] ow_addr,
  input  logic [7:0]           ow_q,
  output logic [LUT_AW-1:0]    lut_addr,
  input  logic [7:0]           lut_q,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           digit,
  output logic [7:0]           max_val
);

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic [IA_W-1:0] I_LAST = IA_W'(N_IN - 1);
  localparam logic [HA_W-1:0] H_LAST = HA_W'(N_HID - 1);
  localparam logic [OA_W-1:0] O_LAST = OA_W'(N_OUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_H_MAC,
    S_H_DRAIN,
    S_H_LUT,
    S_H_WR,
    S_O_MAC,
    S_O_DRAIN,
    S_O_LUT,
    S_O_WR,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [IA_W-1:0]            i_q, i_d;
  logic [HA_W-1:0]            h_q, h_d;
  logic [OA_W-1:0]            o_q, o_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [DATA_W-1:0]   hidden_q [N_HID];
  logic signed [DATA_W-1:0]   hidden_d [N_HID];
  logic                       vld_p1_q, vld_p1_d;
  logic                       lyr_p1_q, lyr_p1_d;
  logic signed [DATA_W-1:0]   hid_p1_q, hid_p1_d;
  logic                       done_q, done_d;
  logic [3:0]                 digit_q, digit_d;
  logic [7:0]                 max_q, max_d;

  logic signed [DATA_W-1:0]   op_a;
  logic signed [COEF_W-1:0]   op_b;
  logic signed [PROD_W-1:0]   prod;

  // Sign-extend one product term to the accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // Scale the accumulator by FRAC and clamp it to the signed LUT_AW-bit range.
  // The in-range test looks at every bit above the kept field plus its sign bit.
  function automatic logic [LUT_AW-1:0] sat_idx(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-FRAC-LUT_AW:0] top;
    top = a[ACC_W-1:FRAC+LUT_AW-1];
    if ((&top) || (~|top)) begin
      return a[FRAC+LUT_AW-1:FRAC];
    end else if (a[ACC_W-1]) begin
      return {1'b1, {(LUT_AW-1){1'b0}}};
    end else begin
      return {1'b0, {(LUT_AW-1){1'b1}}};
    end
  endfunction

  // Add half the LUT range so the most negative value maps to entry 0.
  function automatic logic [LUT_AW-1:0] lut_index(input logic [LUT_AW-1:0] s);
    return {~s[LUT_AW-1], s[LUT_AW-2:0]};
  endfunction

  // Stage p1: operands returning from the memories, one cycle after issue.
  // Pixels are binary; a set pixel contributes +127.
  always_comb begin
    if (lyr_p1_q) begin
      op_a = hid_p1_q;
      op_b = $signed(ow_q);
    end else begin
      op_a = in_q ? $signed({1'b0, {(DATA_W-1){1'b1}}}) : '0;
      op_b = $signed(hw_q);
    end
    prod = op_a * op_b;
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    h_d      = h_q;
    o_d      = o_q;
    acc_d    = acc_q;
    hidden_d = hidden_q;
    digit_d  = digit_q;
    max_d    = max_q;
    // Stage p0 -> p1: flag issued reads and align the register-file operand.
    vld_p1_d = (state_q == S_H_MAC) || (state_q == S_O_MAC);
    lyr_p1_d = (state_q == S_O_MAC);
    hid_p1_d = hidden_q[h_q];

    // Stage p1 -> acc: the DRAIN states absorb the final product here.
    if (vld_p1_q) begin
      acc_d = acc_q + sext_prod(prod);
    end

    unique case (state_q)
      S_IDLE: begin
        acc_d = '0;
        if (start) begin
          state_d = S_H_MAC;
          i_d     = '0;
          h_d     = '0;
          o_d     = '0;
        end
      end
      S_H_MAC: begin
        if (i_q == I_LAST) begin
          state_d = S_H_DRAIN;
        end else begin
          i_d = i_q + IA_W'(1);
        end
      end
      S_H_DRAIN: state_d = S_H_LUT;
      S_H_LUT:   state_d = S_H_WR;
      S_H_WR: begin
        hidden_d[h_q] = $signed(lut_q);
        acc_d         = '0;
        i_d           = '0;
        if (h_q == H_LAST) begin
          h_d     = '0;
          state_d = S_O_MAC;
        end else begin
          h_d     = h_q + HA_W'(1);
          state_d = S_H_MAC;
        end
      end
      S_O_MAC: begin
        if (h_q == H_LAST) begin
          state_d = S_O_DRAIN;
        end else begin
          h_d = h_q + HA_W'(1);
        end
      end
      S_O_DRAIN: state_d = S_O_LUT;
      S_O_LUT:   state_d = S_O_WR;
      S_O_WR: begin
        // Output 0 always seeds the search; later outputs must be strictly
        // larger, so ties resolve to the lowest index.
        if ((o_q == '0) || (lut_q > max_q)) begin
          max_d   = lut_q;
          digit_d = 4'(o_q);
        end
        acc_d = '0;
        h_d   = '0;
        if (o_q == O_LAST) begin
          state_d = S_DONE;
        end else begin
          o_d     = o_q + OA_W'(1);
          state_d = S_O_MAC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort discards the run in progress but keeps the last reported result.
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      i_d      = '0;
      h_d      = '0;
      o_d      = '0;
      acc_d    = '0;
      vld_p1_d = 1'b0;
      hidden_d = hidden_q;
      digit_d  = digit_q;
      max_d    = max_q;
    end

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      h_q      <= '0;
      o_q      <= '0;
      acc_q    <= '0;
      vld_p1_q <= 1'b0;
      lyr_p1_q <= 1'b0;
      hid_p1_q <= '0;
      done_q   <= 1'b0;
      digit_q  <= '0;
      max_q    <= '0;
      for (int k = 0; k < N_HID; k++) begin
        hidden_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      h_q      <= h_d;
      o_q      <= o_d;
      acc_q    <= acc_d;
      vld_p1_q <= vld_p1_d;
      lyr_p1_q <= lyr_p1_d;
      hid_p1_q <= hid_p1_d;
      done_q   <= done_d;
      digit_q  <= digit_d;
      max_q    <= max_d;
      hidden_q <= hidden_d;
    end
  end

  // Addresses are driven only in the states that issue them and are 0 otherwise.
  assign in_addr  = (state_q == S_H_MAC) ? i_q : '0;
  assign hw_addr  = (state_q == S_H_MAC) ? {h_q, i_q} : '0;
  assign ow_addr  = (state_q == S_O_MAC) ? {o_q, h_q} : '0;
  assign lut_addr = ((state_q == S_H_LUT) || (state_q == S_O_LUT)) ?
                    lut_index(sat_idx(acc_q)) : '0;

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign digit   = digit_q;
  assign max_val = max_q;

endmodule

// File: tb/tb_snn_core_param.sv
module tb_snn_core_param;

  localparam int NI  = 4;
  localparam int NH  = 2;
  localparam int NO  = 3;
  localparam int IA  = 2;
  localparam int HA  = 1;
  localparam int OA  = 2;
  localparam int LAW = 11;
  localparam int FR  = 7;
  localparam int L   = NH * (NI + 3) + NO * (NH + 3) + 1;
  localparam int B   = NH * (NI + 3);
  localparam int BIG_NI = 784;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // small configuration
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [IA-1:0]     in_addr;
  logic              in_q;
  logic [HA+IA-1:0]  hw_addr;
  logic [7:0]        hw_q;
  logic [OA+HA-1:0]  ow_addr;
  logic [7:0]        ow_q;
  logic [LAW-1:0]    lut_addr;
  logic [7:0]        lut_q;
  logic              busy, done;
  logic [3:0]        digit;
  logic [7:0]        max_val;

  // default configuration, constant memory data
  logic              start_b = 1'b0;
  logic              abort_b = 1'b0;
  logic [9:0]        in_addr_b;
  logic              in_q_b = 1'b1;
  logic [14:0]       hw_addr_b;
  logic [7:0]        hw_q_b = 8'h00;
  logic [8:0]        ow_addr_b;
  logic [7:0]        ow_q_b = 8'h00;
  logic [10:0]       lut_addr_b;
  logic [7:0]        lut_q_b = 8'h00;
  logic              busy_b, done_b;
  logic [3:0]        digit_b;
  logic [7:0]        max_val_b;

  logic       pix     [NI];
  logic [7:0] hw_mem  [1 << (HA + IA)];
  logic [7:0] ow_mem  [1 << (OA + HA)];
  logic [7:0] lut_mem [1 << LAW];

  int checks = 0;
  int failures = 0;
  int exp_hl [NH];
  int exp_ol [NO];
  int exp_digit = 0;
  int exp_max = 0;

  always #5 clk = ~clk;

  snn_core_param #(.N_IN(NI), .N_HID(NH), .N_OUT(NO), .ACC_W(26), .FRAC(FR), .LUT_AW(LAW)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_addr(in_addr), .in_q(in_q), .hw_addr(hw_addr), .hw_q(hw_q),
    .ow_addr(ow_addr), .ow_q(ow_q), .lut_addr(lut_addr), .lut_q(lut_q),
    .busy(busy), .done(done), .digit(digit), .max_val(max_val)
  );

  snn_core_param u_big (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .in_addr(in_addr_b), .in_q(in_q_b), .hw_addr(hw_addr_b), .hw_q(hw_q_b),
    .ow_addr(ow_addr_b), .ow_q(ow_q_b), .lut_addr(lut_addr_b), .lut_q(lut_q_b),
    .busy(busy_b), .done(done_b), .digit(digit_b), .max_val(max_val_b)
  );

  // synchronous memories with one cycle of read latency
  always @(posedge clk) begin
    in_q  <= pix[in_addr];
    hw_q  <= hw_mem[hw_addr];
    ow_q  <= ow_mem[ow_addr];
    lut_q <= lut_mem[lut_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // accumulator -> LUT address: floor(acc / 2^FRAC) clamped to signed range, offset by half
  function automatic int lut_of(input int acc);
    int v;
    v = acc >>> FR;
    if (v > (1 << (LAW - 1)) - 1) v = (1 << (LAW - 1)) - 1;
    if (v < -(1 << (LAW - 1))) v = -(1 << (LAW - 1));
    return v + (1 << (LAW - 1));
  endfunction

  task automatic model();
    int acc, w, a;
    logic [7:0] hv [NH];
    logic [7:0] ov;
    for (int h = 0; h < NH; h++) begin
      acc = 0;
      for (int i = 0; i < NI; i++) begin
        w = $signed(hw_mem[h * (1 << IA) + i]);
        acc += (pix[i] ? 127 : 0) * w;
      end
      exp_hl[h] = lut_of(acc);
      hv[h] = lut_mem[exp_hl[h]];
    end
    for (int o = 0; o < NO; o++) begin
      acc = 0;
      for (int h = 0; h < NH; h++) begin
        a = $signed(hv[h]);
        w = $signed(ow_mem[o * (1 << HA) + h]);
        acc += a * w;
      end
      exp_ol[o] = lut_of(acc);
      ov = lut_mem[exp_ol[o]];
      if (o == 0 || int'(ov) > exp_max) begin
        exp_max = ov;
        exp_digit = o;
      end
    end
  endtask

  task automatic randomize_mems();
    for (int i = 0; i < NI; i++) pix[i] = 1'($urandom_range(0, 1));
    for (int j = 0; j < (1 << (HA + IA)); j++) hw_mem[j] = 8'($urandom);
    for (int j = 0; j < (1 << (OA + HA)); j++) ow_mem[j] = 8'($urandom);
    for (int j = 0; j < (1 << LAW); j++) lut_mem[j] = 8'($urandom);
  endtask

  task automatic clear_mems();
    for (int i = 0; i < NI; i++) pix[i] = 1'b0;
    for (int j = 0; j < (1 << (HA + IA)); j++) hw_mem[j] = 8'h00;
    for (int j = 0; j < (1 << (OA + HA)); j++) ow_mem[j] = 8'h00;
    for (int j = 0; j < (1 << LAW); j++) lut_mem[j] = 8'h00;
  endtask

  // full run on the small core; repulse_k >= 0 raises start again mid-run
  task automatic run_small(input string tag, input int repulse_k);
    int dcount;
    int first_done;
    model();
    start = 1'b1;
    step();
    start = 1'b0;
    dcount = 0;
    first_done = -1;
    for (int k = 0; k < L + 3; k++) begin
      start = (k == repulse_k);
      for (int h = 0; h < NH; h++)
        if (k == h * (NI + 3) + NI + 1) chk({tag, "_hid_lut_addr"}, 32'(lut_addr), exp_hl[h]);
      for (int o = 0; o < NO; o++)
        if (k == B + o * (NH + 3) + NH + 1) chk({tag, "_out_lut_addr"}, 32'(lut_addr), exp_ol[o]);
      if (k == 0) chk({tag, "_busy_start"}, 32'(busy), 1);
      if (done === 1'b1) begin
        dcount++;
        if (first_done < 0) first_done = k;
      end
      step();
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, first_done, L - 1);
    chk({tag, "_done_count"}, dcount, 1);
    chk({tag, "_busy_end"}, 32'(busy), 0);
    chk({tag, "_digit"}, 32'(digit), exp_digit);
    chk({tag, "_max_val"}, 32'(max_val), exp_max);
  endtask

  task automatic chk_reset_small(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_digit"}, 32'(digit), 0);
    chk({tag, "_max_val"}, 32'(max_val), 0);
    chk({tag, "_in_addr"}, 32'(in_addr), 0);
    chk({tag, "_hw_addr"}, 32'(hw_addr), 0);
    chk({tag, "_ow_addr"}, 32'(ow_addr), 0);
    chk({tag, "_lut_addr"}, 32'(lut_addr), 0);
  endtask

  task automatic run_sat(input string tag, input logic [7:0] w, input int expa);
    hw_q_b = w;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int k = 0; k < BIG_NI + 1; k++) step();
    chk({tag, "_lut_addr"}, 32'(lut_addr_b), expa);
    chk({tag, "_busy"}, 32'(busy_b), 1);
    abort_b = 1'b1;
    step();
    abort_b = 1'b0;
    chk({tag, "_abort_busy"}, 32'(busy_b), 0);
    chk({tag, "_abort_done"}, 32'(done_b), 0);
  endtask

  initial begin
    int sv_digit, sv_max, dcount;
    clear_mems();

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk_reset_small("reset");
    chk("reset_big_busy", 32'(busy_b), 0);
    chk("reset_big_done", 32'(done_b), 0);
    chk("reset_big_digit", 32'(digit_b), 0);
    chk("reset_big_max", 32'(max_val_b), 0);
    chk("reset_big_in_addr", 32'(in_addr_b), 0);
    chk("reset_big_hw_addr", 32'(hw_addr_b), 0);
    chk("reset_big_ow_addr", 32'(ow_addr_b), 0);
    chk("reset_big_lut_addr", 32'(lut_addr_b), 0);
    #2;
    rst_n = 1'b1;
    step();

    // all-zero operands, LUT returns its address low byte
    for (int j = 0; j < (1 << LAW); j++) lut_mem[j] = 8'(j);
    run_small("zero", -1);
    chk("zero_lut_center", exp_hl[0], 32'h400);
    chk("zero_digit_const", 32'(digit), 0);
    chk("zero_max_const", 32'(max_val), 0);

    // argmax: outputs 0x10, 0x40, 0x40 -> index 1 wins the tie
    clear_mems();
    lut_mem[11'h400] = 8'h40;
    lut_mem[11'h401] = 8'h10;
    lut_mem[11'h402] = 8'h40;
    ow_mem[0] = 8'd2;
    ow_mem[2] = 8'd4;
    ow_mem[4] = 8'd4;
    run_small("argmax", -1);
    chk("argmax_digit_const", 32'(digit), 1);
    chk("argmax_max_const", 32'(max_val), 32'h40);

    // all outputs equal -> index 0
    clear_mems();
    lut_mem[11'h400] = 8'h55;
    run_small("equal", -1);
    chk("equal_digit_const", 32'(digit), 0);
    chk("equal_max_const", 32'(max_val), 32'h55);

    // random operands, start re-pulsed while busy in two of the runs
    randomize_mems();
    run_small("rand0", -1);
    randomize_mems();
    run_small("rand1", 5);
    randomize_mems();
    run_small("rand2", B + 2);

    // abort during the output layer
    sv_digit = exp_digit;
    sv_max = exp_max;
    randomize_mems();
    model();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < B + 1; k++) step();
    chk("abort_busy_before", 32'(busy), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_digit_kept", 32'(digit), sv_digit);
    chk("abort_max_kept", 32'(max_val), sv_max);
    dcount = 0;
    for (int k = 0; k < L + 5; k++) begin
      if (done === 1'b1) dcount++;
      step();
    end
    chk("abort_no_done", dcount, 0);
    run_small("after_abort", -1);

    // asynchronous reset in the middle of the hidden MAC
    randomize_mems();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("midrst_busy_before", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_small("midrst");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    run_small("after_reset", -1);

    // saturation on the full-size core
    run_sat("sat_pos", 8'h7F, 32'h7FF);
    run_sat("sat_neg", 8'h80, 32'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snn_core_param.md
Name: snn_core_param

Overview:
- Parametrised two-layer fully-connected inference core: input layer → hidden layer → output layer, followed by an argmax over the outputs.
- Every neuron in both layers is an 8-bit signed multiply-accumulate, then saturation, then an activation-LUT lookup.
- All weights, input pixels and the activation LUT sit in external synchronous memories with 1-cycle read latency. Hidden activations are held in an internal register file.
- Adds to the existing fixed 784/32/10 core: configurable layer sizes, start/busy/done handshake, abort, argmax seeded from output 0 with lowest-index tie-break, and a `max_val` output.

Parameters:
- `N_IN`, 784: number of input units (binary pixels).
- `N_HID`, 32: number of hidden units.
- `N_OUT`, 10: number of output units; must be ≤ 16.
- `ACC_W`, 26: accumulator width, signed.
- `FRAC`, 7: right shift applied to the accumulator before LUT indexing.
- `LUT_AW`, 11: activation LUT address width.
- Derived: `IA_W` = clog2(N_IN), `HA_W` = clog2(N_HID), `OA_W` = clog2(N_OUT).

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: begin inference; sampled only in IDLE.
- `abort`, input, 1: synchronous abort; returns the core to IDLE.
- `in_addr`, output, IA_W: input-pixel memory address.
- `in_q`, input, 1: pixel data, valid 1 cycle after `in_addr`.
- `hw_addr`, output, HA_W+IA_W: hidden-weight address = {h, i}.
- `hw_q`, input, 8: signed hidden weight, 1-cycle latency.
- `ow_addr`, output, OA_W+HA_W: output-weight address = {o, h}.
- `ow_q`, input, 8: signed output weight, 1-cycle latency.
- `lut_addr`, output, LUT_AW: activation LUT address.
- `lut_q`, input, 8: unsigned activation, 1-cycle latency.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when a result is ready.
- `digit`, output, 4: argmax index.
- `max_val`, output, 8: activation of the winning output.

Behaviour:
- **Reset:** state=IDLE; all counters, the accumulator and the hidden register file clear to 0; `busy`=0, `done`=0, `digit`=0, `max_val`=0, all address outputs 0.
- **States:** IDLE, H_MAC, H_DRAIN, H_LUT, H_WR, O_MAC, O_DRAIN, O_LUT, O_WR, DONE.
- **IDLE:** accumulator held clear; `start`=1 moves to H_MAC with i=h=o=0.
- **H_MAC:** each cycle issue `in_addr`=i and `hw_addr`={h,i}, then i++. After i=N_IN-1 is issued, go to H_DRAIN.
- **Hidden MAC data path:**
  - A 1-cycle valid pipe flags the returning data.
  - Pixel extension: `in_q`=1 → 8'h7F, `in_q`=0 → 8'h00.
  - acc += ext × `hw_q`, computed as a signed 8×8 product sign-extended to ACC_W.
  - The final product is accumulated in H_DRAIN.
- **Saturation (combinational on acc):**
  - s = acc[FRAC+LUT_AW-1:FRAC] when acc[ACC_W-1:FRAC+LUT_AW-1] is all 0s or all 1s.
  - Otherwise s = 0x3FF if acc is positive, 0x400 if negative.
  - `lut_addr` = s + 0x400, modulo 2^LUT_AW.
- **H_LUT:** `lut_addr` is presented. **H_WR:** write `lut_q` into hidden[h], clear acc and i, then h++. If h was N_HID-1, clear h and go to O_MAC; else go to H_MAC.
- **Output layer:** O_MAC / O_DRAIN / O_LUT mirror the hidden layer.
  - Operands: hidden[h] (signed) × `ow_q`, with `ow_addr`={o,h} and counter h running 0..N_HID-1.
  - The hidden file is read combinationally but aligned through the same 1-cycle pipe.
- **O_WR:**
  - If o==0, or `lut_q` > `max_val` (unsigned, strict), load `max_val`=`lut_q` and `digit`=o. Ties therefore keep the lowest index.
  - Then clear acc and h, and o++. If o was N_OUT-1, go to DONE; else go to O_MAC.
- **DONE:** `done`=1 for exactly this cycle, then go to IDLE. `digit` and `max_val` hold until the O_WR of o=0 in the next run.
- **Latency:** with L = N_HID·(N_IN+3) + N_OUT·(N_HID+3) + 1, `done` is high in the cycle after the L-th rising edge counted from the edge that samples `start`. Defaults give L = 25535.
- **`start` while busy:** ignored, no effect.
- **`abort`:** in any non-IDLE state, the next state is IDLE, counters and acc are cleared, and no `done` pulse is produced. `digit`/`max_val` keep their last values. `abort` has priority over `start`. `abort` in IDLE has no effect.
- **Reset mid-operation:** immediate return to reset values.
- **Counters:** no wrap past their bounds. Addresses for an unused {h,i} padding range are never issued.

Test Plan:
- **Latency and default result** (N_IN=4, N_HID=2, N_OUT=3; all pixels 0, all weights 0, LUT returns address[7:0]): start → every `lut_addr`=0x400, `done` 30 cycles after start, `digit`=0, `max_val`=0x00.
- **Positive saturation:** pixels all 1, `hw_q`=8'h7F, N_IN=784 (acc=784·127·127) → hidden `lut_addr`=0x7FF.
- **Negative saturation:** pixels all 1, `hw_q`=8'h80 → hidden `lut_addr`=0x000.
- **Argmax:** output activations {0x10,0x40,0x40} → `digit`=1, `max_val`=0x40. All-equal activations → `digit`=0.
- **Handshake:** start pulsed again mid-run → ignored, exactly one `done`. `abort` during O_MAC → IDLE next cycle, `busy`=0, no `done`, and a restart gives a correct result.
- **Reset:** `rst_n` low during H_MAC → all outputs at reset values asynchronously. After release, a new run matches the golden model.
